// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. It resolves
// data-memory wait states, multi-cycle MDU operations, taken branches and
// load-use hazards. It drives the hold/clear controls of PC, IF/ID, ID/EX and
// EX/MEM, and also keeps a sticky memory-timeout flag and two saturating
// performance counters.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   id_rs1/id_rs2       source register indices of the ID instruction
//   id_use_rs1/_rs2     ID instruction actually reads that source
//   ex_rd, ex_memread   destination and "is a load" of the EX instruction
//   ex_branch_taken     EX resolved a taken branch/jump
//   ex_mdu_valid        EX holds a multi-cycle MDU op
//   mdu_done            MDU result valid this cycle
//   dmem_req, dmem_ack  MEM-stage data access and its completion
//   pc_stall .. ex_mem_bubble   combinational pipeline controls
//   mem_err             sticky memory-timeout error
//   stall_cnt/flush_cnt cycles with pc_stall / if_id_flush (saturating)
//   state_dbg           current FSM state (0 RUN, 1 MEM_WAIT, 2 MDU_WAIT)
//
// Handshake note: dmem_req/dmem_ack is a level protocol. The access is
// outstanding while dmem_req=1. It completes in the cycle where dmem_ack=1.
// The same pattern applies to ex_mdu_valid/mdu_done.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_valid,
    input  logic             mdu_done,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_dbg
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MDU_WAIT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_MEM,
        ACT_MDU,
        ACT_BRANCH,
        ACT_LOAD_USE
    } act_t;

    state_t           state, state_nxt;
    act_t             act, run_act;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic             mem_hold, mdu_hold, load_use, tmo_hit;

    assign mem_hold = dmem_req & ~dmem_ack;
    assign mdu_hold = ex_mdu_valid & ~mdu_done;
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // The counter also counts the RUN cycle that entered the wait, so it
    // holds the total number of frozen cycles spent on this access.
    assign tmo_hit  = (state == ST_MEM_WAIT) && mem_hold &&
                      (tmo_cnt == TMO_W'(MEM_TIMEOUT));
    assign state_dbg = state;

    // Action decode: one place holds the priority order that both the
    // next-state and output logic follow.
    always_comb begin
        run_act = ACT_NONE;
        if (mdu_hold)             run_act = ACT_MDU;
        else if (ex_branch_taken) run_act = ACT_BRANCH;
        else if (load_use)        run_act = ACT_LOAD_USE;

        act = run_act;
        unique case (state)
            ST_RUN:      if (mem_hold) act = ACT_MEM;
            ST_MEM_WAIT: begin
                if (tmo_hit)       act = ACT_NONE;   // abort: release the pipe
                else if (mem_hold) act = ACT_MEM;    // branch flush deferred
            end
            ST_MDU_WAIT: begin
                if (mem_hold)      act = ACT_MEM;
                else if (mdu_hold) act = ACT_MDU;
                else               act = ACT_NONE;   // result enters EX/MEM
            end
            default:     act = ACT_NONE;
        endcase
    end

    // State register, timeout counter, error flag and performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            tmo_cnt   <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
            if (tmo_hit)
                mem_err <= 1'b1;
            if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (if_id_flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Next-state logic. The counter runs only while memory freezes the pipe.
    always_comb begin
        state_nxt = ST_RUN;
        tmo_nxt   = '0;
        unique case (act)
            ACT_MEM: begin
                state_nxt = ST_MEM_WAIT;
                tmo_nxt   = tmo_cnt + 1'b1;
            end
            ACT_MDU: state_nxt = ST_MDU_WAIT;
            default: state_nxt = ST_RUN;
        endcase
    end

    // Output logic (Mealy). Everything is forced low while reset is held.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        if (!rst) begin
            unique case (act)
                ACT_MEM: begin
                    // EX/MEM holds through the global memory freeze.
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                end
                ACT_MDU: begin
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_ex_stall   = 1'b1;
                    ex_mem_bubble = 1'b1;
                end
                ACT_BRANCH: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                ACT_LOAD_USE: begin
                    // A single bubble is enough: the load moves to MEM next cycle.
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
